int_ctrl: RTL

//   Interrupt controller between device IRQ lines and the CP0 HWInt[5:0] input. It synchronises raw lines and latches

---
 rtl/int_ctrl_if.sv | 17 +
 rtl/int_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if -- bridge register bus for the interrupt controller.
//   addr : word address (byte addr[3:2])
//   we   : write strobe, sampled on the clock edge
//   wd   : write data
//   rd   : read data, combinational on addr
// master = bridge side, slave = int_ctrl side.
// -----------------------------------------------------------------------------
interface int_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, output we, output wd, input rd);
    modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- interrupt controller feeding CP0 HWInt[5:0].
// Synchronises raw IRQ lines, latches edge/level pending bits, and presents
// one fixed-priority winner (lowest index first) until software clears it or
// ERET retires it.
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active low
//   irq_in     raw device interrupt lines (asynchronous)
//   bus        bridge register bus (addr/we/wd/rd)
//               0 PEND (RO), 1 ENABLE, 2 MODE (1=edge), 3 CLEAR (W1C) /
//               status read {busy, 0, id[2:0]}
//   int_taken  CP0 entered the handler on an interrupt (1-cycle pulse)
//   eret       ERET committed (1-cycle pulse)
//   hwint      registered one-hot winner, 0 when nothing is being issued
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    int_ctrl_if.slave       bus,
    input  logic            int_taken,
    input  logic            eret,
    output logic [5:0]      hwint
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_PEND   = 2'd0;
    localparam logic [1:0] A_ENABLE = 2'd1;
    localparam logic [1:0] A_MODE   = 2'd2;
    localparam logic [1:0] A_CLEAR  = 2'd3;

    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] en_q, en_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [2:0]      id_q, id_d;
    state_t          state_q, state_d;
    logic [5:0]      hwint_q, hwint_d;

    logic [NSRC-1:0] rise, act, clr;
    logic [2:0]      win;
    logic [7:0]      pend8;
    logic            wr_clr, id_cleared, busy;

    assign rise   = s2_q & ~s3_q;
    assign act    = pend_q & en_q;
    assign wr_clr = bus.we && (bus.addr == A_CLEAR);
    assign clr    = wr_clr ? bus.wd[NSRC-1:0] : '0;
    assign busy   = (state_q != IDLE);
    // Padded copy so id can index PEND safely for any NSRC.
    assign pend8  = 8'(pend_q);
    assign id_cleared = wr_clr && bus.wd[id_q];

    // Fixed priority: lowest set index wins.
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) win = 3'(i);
        end
    end

    always_comb begin
        // Edge lines: a rise in the same cycle as a clear keeps the bit set.
        // Level lines simply track the synchronised input.
        pend_d  = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & s2_q);
        en_d    = (bus.we && bus.addr == A_ENABLE) ? bus.wd[NSRC-1:0] : en_q;
        mode_d  = (bus.we && bus.addr == A_MODE)   ? bus.wd[NSRC-1:0] : mode_q;
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (act != '0) begin
                    state_d = ISSUE;
                    id_d    = win;
                end
            end
            ISSUE: begin
                // Taken beats a vanishing request: CP0 is already in the handler.
                if (int_taken) begin
                    state_d = SERVICE;
                end else if (act == '0) begin
                    state_d = IDLE;
                end else begin
                    id_d = win;
                end
            end
            SERVICE: begin
                if (id_cleared || eret || !pend8[id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered so hwint reflects the state it is paired with.
        hwint_d = (state_d == ISSUE) ? (6'b1 << id_d) : 6'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            id_q    <= '0;
            state_q <= IDLE;
            hwint_q <= '0;
        end else begin
            s1_q    <= irq_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
            state_q <= state_d;
            hwint_q <= hwint_d;
        end
    end

    assign hwint = hwint_q;

    always_comb begin
        bus.rd = '0;
        unique case (bus.addr)
            A_PEND:   bus.rd = 32'(pend_q);
            A_ENABLE: bus.rd = 32'(en_q);
            A_MODE:   bus.rd = 32'(mode_q);
            A_CLEAR:  bus.rd = {27'b0, busy, 1'b0, id_q};
            default:  bus.rd = '0;
        endcase
    end

endmodule
